// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, opcode encoding, writeback FSM states
// and opcode classification helpers.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_SRL = 3'b100,
        OP_SLL = 3'b101,
        OP_AND = 3'b110,
        OP_OR  = 3'b111
    } opcode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WR_HI = 1'b1
    } wb_state_t;

    // Multiply and divide/remainder produce a 64-bit result that needs two registers.
    function automatic logic is_wide(input opcode_t op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic sets_ov(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_writeback_rf_if.sv
// Valid/ready result channel from the ALU into the writeback stage.
interface alu_writeback_rf_if #(
    parameter int AW = 5
);
    import alu_pkg::*;

    logic          in_valid;
    logic          in_ready;
    opcode_t       in_opcode;
    logic [63:0]   in_res;
    logic          in_ov;
    logic [AW-1:0] in_rd;

    modport master (
        output in_valid,
        output in_opcode,
        output in_res,
        output in_ov,
        output in_rd,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_opcode,
        input  in_res,
        input  in_ov,
        input  in_rd,
        output in_ready
    );

endinterface

// File: rtl/alu_writeback_rf_rf_array.sv
// Register file: one synchronous write port, two combinational read ports,
// r0 hardwired to zero. No write-to-read bypass.
module rf_array #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data
);

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : mem[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : mem[rs2_addr];
    end

endmodule

// File: rtl/alu_writeback_rf.sv
// ALU writeback stage: accepts results over valid/ready, writes narrow results
// in one cycle and wide (64-bit) results as two registers over two cycles.
module alu_writeback_rf
    import alu_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_writeback_rf_if.slave    bus,
    input  logic [AW-1:0]        rs1_addr,
    output logic [XLEN-1:0]      rs1_data,
    input  logic [AW-1:0]        rs2_addr,
    output logic [XLEN-1:0]      rs2_data,
    input  logic                 ov_clr,
    output logic                 ov_sticky,
    output logic [CNTW-1:0]      retired,
    output logic                 busy
);

    wb_state_t       state_q, state_d;
    logic [XLEN-1:0] hi_q;
    logic [AW-1:0]   hi_rd_q;

    logic            accept;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            inc;
    logic            ov_set;

    assign bus.in_ready = (state_q == IDLE) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign busy         = (state_q == WR_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        inc     = 1'b0;
        ov_set  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    wr_addr = bus.in_rd;
                    wr_data = bus.in_res[XLEN-1:0];
                    ov_set  = sets_ov(bus.in_opcode) && bus.in_ov;
                    if (is_wide(bus.in_opcode)) begin
                        state_d = WR_HI;
                    end else begin
                        inc = 1'b1;
                    end
                end
            end
            WR_HI: begin
                wr_en   = 1'b1;
                wr_addr = hi_rd_q;
                wr_data = hi_q;
                inc     = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // hi_rd wraps mod NREGS through the AW-bit add, so rd=31 targets r0 and is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q      <= '0;
            hi_rd_q   <= '0;
            ov_sticky <= 1'b0;
            retired   <= '0;
        end else begin
            if (accept && is_wide(bus.in_opcode)) begin
                hi_q    <= bus.in_res[63:32];
                hi_rd_q <= bus.in_rd + AW'(1);
            end
            ov_sticky <= ov_set | (ov_sticky & ~ov_clr);
            retired   <= retired + CNTW'(inc);
        end
    end

    rf_array #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rs1_addr (rs1_addr),
        .rs1_data (rs1_data),
        .rs2_addr (rs2_addr),
        .rs2_data (rs2_data)
    );

endmodule

// File: tb/tb_alu_writeback_rf.sv
// Directed self-checking bench for alu_writeback_rf.
module tb_alu_writeback_rf;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        ov_clr;
    logic        ov_sticky;
    logic [15:0] retired;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_writeback_rf_if #(.AW(5)) bus ();

    alu_writeback_rf #(
        .NREGS (32),
        .AW    (5),
        .CNTW  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .rs1_addr  (rs1_addr),
        .rs1_data  (rs1_data),
        .rs2_addr  (rs2_addr),
        .rs2_data  (rs2_data),
        .ov_clr    (ov_clr),
        .ov_sticky (ov_sticky),
        .retired   (retired),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd1(input logic [4:0] a, input logic [31:0] exp, input string tag);
        rs1_addr = a;
        #1;
        check(tag, 64'(rs1_data), 64'(exp));
    endtask

    task automatic rd2(input logic [4:0] a, input logic [31:0] exp, input string tag);
        rs2_addr = a;
        #1;
        check(tag, 64'(rs2_data), 64'(exp));
    endtask

    task automatic drive(input opcode_t op, input logic [63:0] res, input logic ov, input logic [4:0] rd);
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_res    = res;
        bus.in_ov     = ov;
        bus.in_rd     = rd;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_opcode = OP_ADD;
        bus.in_res    = '0;
        bus.in_ov     = 1'b0;
        bus.in_rd     = '0;
        rs1_addr      = '0;
        rs2_addr      = '0;
        ov_clr        = 1'b0;

        tick();
        tick();
        check("ready_in_reset", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", 64'(bus.in_ready), 64'd1);
        check("retired_reset", 64'(retired), 64'd0);
        check("ov_reset", 64'(ov_sticky), 64'd0);
        check("busy_reset", 64'(busy), 64'd0);
        for (int i = 0; i < 32; i++) begin
            rd1(5'(i), 32'h0, "reg_reset");
        end

        // Narrow stream, back to back
        drive(OP_ADD, 64'h0000_0000_1234_5678, 1'b0, 5'd3);
        rd1(5'd3, 32'h0, "no_bypass_r3");
        tick();
        check("ready_narrow", 64'(bus.in_ready), 64'd1);
        drive(OP_OR, 64'h0000_0000_FFFF_FFFF, 1'b0, 5'd4);
        rd1(5'd3, 32'h1234_5678, "r3_add");
        tick();
        bus.in_valid = 1'b0;
        rd2(5'd4, 32'hFFFF_FFFF, "r4_or");
        check("retired_2", 64'(retired), 64'd2);

        // Wide MUL with a narrow ADD held behind it
        drive(OP_MUL, 64'hDEAD_BEEF_00C0_FFEE, 1'b0, 5'd6);
        tick();
        drive(OP_ADD, 64'h0000_0000_0000_0055, 1'b0, 5'd8);
        check("busy_wr_hi", 64'(busy), 64'd1);
        check("ready_wr_hi", 64'(bus.in_ready), 64'd0);
        rd1(5'd6, 32'h00C0_FFEE, "r6_lo");
        rd2(5'd7, 32'h0, "r7_pending");
        tick();
        check("busy_back_idle", 64'(busy), 64'd0);
        check("ready_back_idle", 64'(bus.in_ready), 64'd1);
        rd1(5'd7, 32'hDEAD_BEEF, "r7_hi");
        rd2(5'd8, 32'h0, "r8_not_yet");
        check("retired_3", 64'(retired), 64'd3);
        tick();
        bus.in_valid = 1'b0;
        rd1(5'd8, 32'h0000_0055, "r8_add");
        check("retired_4", 64'(retired), 64'd4);

        // Wide op to r31: high half wraps to r0 and is dropped
        drive(OP_DIV, 64'h0000_0007_0000_0003, 1'b0, 5'd31);
        tick();
        bus.in_valid = 1'b0;
        tick();
        rd1(5'd31, 32'h3, "r31_lo");
        rd2(5'd0, 32'h0, "r0_zero");
        rd1(5'd1, 32'h0, "r1_untouched");
        check("retired_5", 64'(retired), 64'd5);

        // Narrow write aimed at r0 is dropped
        drive(OP_AND, 64'h0000_0000_ABCD_0123, 1'b0, 5'd0);
        tick();
        bus.in_valid = 1'b0;
        rd1(5'd0, 32'h0, "r0_write_dropped");
        check("retired_6", 64'(retired), 64'd6);

        // Overflow sticky behaviour
        drive(OP_SUB, 64'h0000_0000_0000_0001, 1'b1, 5'd12);
        tick();
        bus.in_valid = 1'b0;
        check("ov_set_sub", 64'(ov_sticky), 64'd1);
        ov_clr = 1'b1;
        tick();
        ov_clr = 1'b0;
        check("ov_clr", 64'(ov_sticky), 64'd0);
        drive(OP_MUL, 64'h0000_0001_0000_0002, 1'b1, 5'd13);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("ov_mul_ignored", 64'(ov_sticky), 64'd0);
        rd1(5'd14, 32'h1, "r14_hi");
        drive(OP_SRL, 64'h0000_0000_0000_0009, 1'b1, 5'd15);
        tick();
        bus.in_valid = 1'b0;
        check("ov_srl_ignored", 64'(ov_sticky), 64'd0);
        drive(OP_SUB, 64'h0000_0000_0000_0004, 1'b1, 5'd12);
        tick();
        drive(OP_ADD, 64'h0000_0000_0000_0005, 1'b1, 5'd12);
        ov_clr = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        ov_clr = 1'b1;
        check("ov_set_wins", 64'(ov_sticky), 64'd1);
        tick();
        ov_clr = 1'b0;
        check("ov_clr_alone", 64'(ov_sticky), 64'd0);
        rd1(5'd12, 32'h5, "r12_add");
        check("retired_11", 64'(retired), 64'd11);

        // Reset while the high half is pending
        drive(OP_MUL, 64'h1111_1111_2222_2222, 1'b0, 5'd10);
        tick();
        bus.in_valid = 1'b0;
        check("busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("ready_rst_high", 64'(bus.in_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("ready_after_midrst", 64'(bus.in_ready), 64'd1);
        check("busy_after_midrst", 64'(busy), 64'd0);
        check("retired_after_midrst", 64'(retired), 64'd0);
        rd1(5'd10, 32'h0, "r10_cleared");
        rd2(5'd11, 32'h0, "r11_cleared");
        tick();
        rd2(5'd11, 32'h0, "r11_no_late_write");
        check("retired_still_0", 64'(retired), 64'd0);

        // Retired counter wrap
        drive(OP_ADD, 64'h0000_0000_0000_0077, 1'b0, 5'd2);
        repeat (65535) tick();
        check("retired_ffff", 64'(retired), 64'h0000_0000_0000_FFFF);
        tick();
        bus.in_valid = 1'b0;
        check("retired_wrap", 64'(retired), 64'd0);
        rd1(5'd2, 32'h77, "r2_stream");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_writeback_rf.md
Name: alu_writeback_rf

Overview:
- Downstream writeback stage for the 32-bit ALU.
- Accepts one ALU result per valid/ready handshake: 64-bit res, ov flag, opcode and destination register index.
- Writes the result into a 32 x 32-bit register file. The register file's two combinational read ports supply the ALU a/b operands.
- 64-bit results (multiply, divide/remainder) are written as two registers over two cycles. Upstream is back-pressured during the second cycle.

Parameters:
- XLEN, 32, register and ALU operand width
- NREGS, 32, number of architectural registers; r0 is hardwired to zero
- AW, 5, register index width (log2 NREGS)
- CNTW, 16, width of the retired-result counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream result valid
- in_ready  out  1  stage can accept a result this cycle
- in_opcode  in  3  ALU opcode that produced in_res
- in_res  in  64  ALU result; [31:0] low half, [63:32] high half
- in_ov  in  1  ALU overflow/carry flag
- in_rd  in  AW  destination register index
- rs1_addr  in  AW  read port 1 index
- rs1_data  out  XLEN  read port 1 data, feeds ALU operand a
- rs2_addr  in  AW  read port 2 index
- rs2_data  out  XLEN  read port 2 data, feeds ALU operand b
- ov_clr  in  1  clear sticky overflow
- ov_sticky  out  1  sticky overflow status
- retired  out  CNTW  count of completed results, wraps modulo 2^CNTW
- busy  out  1  high while in WR_HI state

Behaviour:
- Reset (rst=1 at a rising edge):
  - all registers cleared to 0; state returns to IDLE
  - ov_sticky=0, retired=0, busy=0
  - in_ready is forced 0 while rst is high and is 1 on the first cycle after reset
- Handshake:
  - a transfer occurs on an edge where in_valid && in_ready
  - in_ready = (state==IDLE) && !rst, combinational from state only, never from in_valid
  - while in_valid=1 && in_ready=0, upstream must hold all inputs stable
- Wide ops: opcode 010 (mul) and 011 (div/rem) are wide; all others are narrow.
- State IDLE:
  - narrow accept: in_res[31:0] is written to in_rd at that edge; retired increments; state stays IDLE
  - wide accept: in_res[31:0] is written to in_rd at that edge; in_res[63:32] and hi_rd=(in_rd+1) mod NREGS are latched; next state WR_HI
- State WR_HI:
  - busy=1, in_ready=0
  - at the next edge the latched high half is written to hi_rd; retired increments; next state IDLE
  - throughput: narrow 1 result/cycle, wide 1 result per 2 cycles
- Wrap-around:
  - in_rd=31 on a wide op sends the high half to r0, so the high half is discarded; the retired count is still incremented
  - retired wraps 0xFFFF -> 0x0000
- r0:
  - writes to r0 are dropped
  - reads of r0 always return 0
- Reads:
  - combinational from the array
  - a write becomes visible on the cycle after its edge
  - no same-cycle bypass: a read of the address being written returns the old value
- Overflow:
  - ov_sticky is set on accept of opcode 000 or 001 with in_ov=1; in_ov on other opcodes is ignored
  - ov_clr clears ov_sticky
  - if set and clear happen on the same edge, set wins
- Reset mid-operation: rst in WR_HI drops the pending high half (no write) and the state returns to IDLE.
- Latency: accept edge to low-half readability is 1 cycle; high half is readable 2 cycles after the accept edge.

Decomposition:
- Shared package alu_pkg:
  - XLEN constant
  - opcode enum OP_ADD=000, OP_SUB=001, OP_MUL=010, OP_DIV=011, OP_SRL=100, OP_SLL=101, OP_AND=110, OP_OR=111
  - function is_wide(opcode)
  - function sets_ov(opcode)
  - wb_state_t enum {IDLE, WR_HI}
- Sub-module rf_array:
  - NREGS x XLEN storage, one synchronous write port, two combinational read ports, r0 hardwired to zero
  - the FSM, counter and ov logic stay in alu_writeback_rf

Test Plan:
- Reset, then read all 32 registers -> all 0x00000000; in_ready=1, retired=0, ov_sticky=0.
- Narrow stream: ADD rd=3 res=0x0000_0000_1234_5678, then OR rd=4 res=0xFFFF_FFFF on consecutive cycles -> in_ready stays 1; r3=0x12345678 and r4=0xFFFFFFFF on the following cycles; retired=2.
- MUL rd=6 res=0xDEADBEEF_00C0FFEE, with a narrow ADD held valid the next cycle:
  - r6=0x00C0FFEE after 1 cycle, r7=0xDEADBEEF after 2 cycles
  - in_ready=0 and busy=1 for exactly one cycle; the ADD is accepted one cycle later
- Wide op to rd=31 (DIV res=0x00000007_00000003) -> r31=3, r0 still reads 0, retired increments by 1.
- Overflow: SUB with in_ov=1 -> ov_sticky=1; MUL with in_ov=1 does not change it; ov_clr asserted on the same edge as an ADD with in_ov=1 -> ov_sticky remains 1; ov_clr alone -> 0.
- Reset during WR_HI after MUL rd=10 res=0x11111111_22222222 -> r10=0 and r11=0 after reset; state IDLE; in_ready=1 on the next cycle; retired=0.
